regfile_wr_sched: RTL and testbench
===================================

Name: regfile_wr_sched

Overview:
- Write-port scheduler and initialiser for the 32x32 MIPS register file (2 read ports, 1 write port).
- After reset, sequences a zero-fill of every register.
- Then shares the single write port between NUM_REQ writeback sources (e.g. ALU, load unit) using round-robin valid/ready arbitration.
- Drives the register file's wr/rw/d; sits between the writeback stage and the register file.

Parameters:
- DATA_WIDTH, 32, word width.
- ADDR_WIDTH, 5, register address width.
- REG_DEPTH, 32, number of registers zero-filled by INIT.
- RD_DEPTH, 2, number of read ports (used by bypass).
- NUM_REQ, 2, number of writeback requesters, 2..8.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous request to re-run the zero-fill.
- stall  in  1  blocks new grants while high.
- req_valid  in  NUM_REQ  per-requester write request.
- req_addr  in  NUM_REQ*ADDR_WIDTH  vectorised write addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_data  in  NUM_REQ*DATA_WIDTH  vectorised write data, same packing.
- req_ready  out  NUM_REQ  one-hot grant (combinational).
- wr  out  1  register file write enable.
- rw  out  ADDR_WIDTH  register file write address.
- d  out  DATA_WIDTH  register file write data.
- rr  in  RD_DEPTH*ADDR_WIDTH  read addresses, as presented to the register file.
- q_rf  in  RD_DEPTH*DATA_WIDTH  raw register file read data.
- q  out  RD_DEPTH*DATA_WIDTH  read data delivered to the datapath.
- init_done  out  1  high in RUN.

Behaviour:
Reset (rst=0, asynchronous):
- state=INIT, init counter=0, rr pointer=0.
- wr=0, rw=0, d=0, init_done=0.

INIT:
- Each cycle registers wr=1, rw=counter, d=0, then increments the counter.
- After issuing REG_DEPTH-1, transitions to RUN.
- Takes exactly REG_DEPTH cycles; init_done rises on the edge after the last fill write issues.
- req_ready=0 throughout. stall and clear are ignored.

RUN:
- Grant: req_ready[i]=1 for the first valid requester at or after the rr pointer (cyclic), only when stall=0 and clear=0.
- At most one bit of req_ready is high. A transfer occurs when req_valid[i]&req_ready[i].
- On transfer, at the next edge: wr=1, rw=req_addr[i], d=req_data[i]; pointer=(i+1) mod NUM_REQ. Latency is 1 cycle from acceptance to wr.
- Without a transfer, the next edge sets wr=0; rw and d hold their values.
- Address 0 ($zero): the request is accepted (ready, pointer advances) but the registered wr=0.
- clear=1 in RUN: no grant that cycle. Next edge: state=INIT, counter=0, init_done=0. Any write already registered in wr/rw/d still completes that cycle.
- Pointer not updated when no transfer. Requesters hold valid/addr/data stable until accepted.
- rst asserted mid-INIT or mid-RUN: immediate return to reset values. A partially filled register file is refilled from 0.

Read path:
- Without the optional feature, q=q_rf.

Optional Feature:
Macro REGFILE_WR_BYPASS_EN.
- Defined: for each read port p, if wr=1 and rr[p]==rw and rr[p]!=0, q[p]=d; otherwise q[p]=q_rf[p]. This is combinational, so the value being written this cycle is visible without waiting for the commit edge.
- Undefined: q=q_rf; no comparators are instantiated.

Decomposition:
- Shared package regfile_pkg: DATA_WIDTH/ADDR_WIDTH/REG_DEPTH/RD_DEPTH defaults, ZERO_REG=0 constant, state encoding (INIT=1'b0, RUN=1'b1).
- One natural sub-module: rr_arbiter (NUM_REQ-wide round-robin grant from valid vector + pointer, combinational, plus pointer register). The FSM, write register and bypass stay in regfile_wr_sched.

Test Plan:
- Reset then release → wr=1 for 32 consecutive cycles, rw=0..31, d=0; init_done=1 on the following cycle; req_ready=0 during fill.
- RUN, req_valid=2'b11, addr0=5'd27/data0=32'hdcaf484c, addr1=5'd4/data1=32'h37373737, pointer=0 → req_ready=01, next cycle wr=1 rw=27 d=dcaf484c; then req_ready=10, next cycle rw=4 d=37373737.
- Requester 0 valid, addr=0, data=32'hffffffff → req_ready[0]=1, following cycle wr=0.
- stall=1 with both valid → req_ready=00, wr=0 next cycle. Release stall → grant goes to the requester at the pointer.
- clear=1 for one cycle in RUN with a write just registered (rw=4) → that write appears (wr=1, rw=4), then 32 fill cycles from rw=0, init_done=0 until done. rst pulsed low at fill address 10 → restart at 0.
- With REGFILE_WR_BYPASS_EN: rr={5'd4,5'd27}, write rw=27 d=32'hdcaf484c in flight, q_rf=0 → q port0=dcaf484c, port1=q_rf. rr=0 during a suppressed write → q=q_rf.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and state encoding for the register-file write scheduler.
package regfile_pkg;

  localparam int unsigned RF_DATA_WIDTH = 32;
  localparam int unsigned RF_ADDR_WIDTH = 5;
  localparam int unsigned RF_REG_DEPTH  = 32;
  localparam int unsigned RF_RD_DEPTH   = 2;

  // Writes to $zero are accepted but never reach the register file.
  localparam int unsigned ZERO_REG = 0;

  typedef enum logic {
    StInit = 1'b0,
    StRun  = 1'b1
  } state_e;

endpackage

// File: rtl/regfile_wr_sched_if.sv
// Writeback request bus plus register-file write/read signals of the write scheduler.
interface regfile_wr_sched_if
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int unsigned RD_DEPTH   = RF_RD_DEPTH,
  parameter int unsigned NUM_REQ    = 2
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;

  logic                          wr;
  logic [ADDR_WIDTH-1:0]         rw;
  logic [DATA_WIDTH-1:0]         d;

  logic [RD_DEPTH*ADDR_WIDTH-1:0] rr;
  logic [RD_DEPTH*DATA_WIDTH-1:0] q_rf;
  logic [RD_DEPTH*DATA_WIDTH-1:0] q;

  // Writeback sources, register file and datapath side.
  modport master (
    output req_valid, req_addr, req_data, rr, q_rf,
    input  req_ready, wr, rw, d, q
  );

  // Scheduler side.
  modport slave (
    input  req_valid, req_addr, req_data, rr, q_rf,
    output req_ready, wr, rw, d, q
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin grant over NUM_REQ valid lines; the pointer moves past each winner.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  localparam int unsigned IdxW = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NUM_REQ-1:0] valid,
  output logic [NUM_REQ-1:0] grant,
  output logic [IdxW-1:0]    grant_idx,
  output logic               transfer
);

  logic [IdxW-1:0] ptr_q, ptr_d, idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    transfer  = 1'b0;
    idx       = '0;
    // Scan cyclically starting at the pointer; first valid wins.
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = IdxW'((32'(ptr_q) + k) % NUM_REQ);
      if (en && !transfer && valid[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        transfer   = 1'b1;
      end
    end
    ptr_d = transfer ? IdxW'((32'(grant_idx) + 32'd1) % NUM_REQ) : ptr_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/regfile_wr_sched.sv
// Register-file write-port scheduler: zero-fill after reset/clear, then round-robin writeback.
// Optional write-to-read bypass enabled by defining REGFILE_WR_BYPASS_EN.
module regfile_wr_sched
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int unsigned REG_DEPTH  = RF_REG_DEPTH,
  parameter int unsigned RD_DEPTH   = RF_RD_DEPTH,
  parameter int unsigned NUM_REQ    = 2,
  localparam int unsigned IdxW = $clog2(NUM_REQ)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic stall,
  output logic init_done,
  regfile_wr_sched_if.slave bus
);

  localparam logic [ADDR_WIDTH-1:0] LastFill = ADDR_WIDTH'(REG_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ZeroAddr = ADDR_WIDTH'(ZERO_REG);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] rw_q, rw_d;
  logic [DATA_WIDTH-1:0] d_q, d_d;

  logic                  arb_en;
  logic [NUM_REQ-1:0]    grant;
  logic [IdxW-1:0]       grant_idx;
  logic                  transfer;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  assign arb_en = (state_q == StRun) && !stall && !clear;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .en        (arb_en),
    .valid     (bus.req_valid),
    .grant     (grant),
    .grant_idx (grant_idx),
    .transfer  (transfer)
  );

  assign sel_addr = bus.req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_data = bus.req_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = 1'b0;
    rw_d    = rw_q;
    d_d     = d_q;
    unique case (state_q)
      StInit: begin
        wr_d = 1'b1;
        rw_d = cnt_q;
        d_d  = '0;
        if (cnt_q == LastFill) begin
          state_d = StRun;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
        end
      end
      StRun: begin
        if (clear) begin
          state_d = StInit;
          cnt_d   = '0;
        end else if (transfer) begin
          wr_d = (sel_addr != ZeroAddr);
          rw_d = sel_addr;
          d_d  = sel_data;
        end
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StInit;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      rw_q    <= '0;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      rw_q    <= rw_d;
      d_q     <= d_d;
    end
  end

  assign bus.req_ready = grant;
  assign bus.wr        = wr_q;
  assign bus.rw        = rw_q;
  assign bus.d         = d_q;
  assign init_done     = (state_q == StRun);

`ifdef REGFILE_WR_BYPASS_EN
  // Forward the in-flight write to any read port addressing the same register.
  for (genvar p = 0; p < RD_DEPTH; p++) begin : g_byp
    logic [ADDR_WIDTH-1:0] rd_addr;
    assign rd_addr = bus.rr[p*ADDR_WIDTH +: ADDR_WIDTH];
    assign bus.q[p*DATA_WIDTH +: DATA_WIDTH] =
        (wr_q && (rd_addr == rw_q) && (rd_addr != ZeroAddr)) ?
        d_q : bus.q_rf[p*DATA_WIDTH +: DATA_WIDTH];
  end
`else
  assign bus.q = bus.q_rf;
`endif

endmodule

// File: tb/tb_regfile_wr_sched.sv
// Randomized self-checking bench for regfile_wr_sched against a behavioural model.
module tb_regfile_wr_sched;

  localparam int NREQ  = 2;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int RD    = 2;
  localparam int DEPTH = 32;

  logic clk;
  logic rst;
  logic clear;
  logic stall;
  logic init_done;

  regfile_wr_sched_if #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .RD_DEPTH   (RD),
    .NUM_REQ    (NREQ)
  ) bus ();

  regfile_wr_sched #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .REG_DEPTH  (DEPTH),
    .RD_DEPTH   (RD),
    .NUM_REQ    (NREQ)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .stall     (stall),
    .init_done (init_done),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Pending requests: each requester holds its request until accepted.
  bit          pv[NREQ];
  logic [AW-1:0] pa[NREQ];
  logic [DW-1:0] pd[NREQ];

  // Behavioural model of the observable state.
  bit          m_run;
  int          m_cnt;
  int          m_ptr;
  bit          m_wr;
  logic [AW-1:0] m_rw;
  logic [DW-1:0] m_d;
  bit          m_known;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_bus();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_valid[i]          = pv[i];
      bus.req_addr[i*AW +: AW]  = pa[i];
      bus.req_data[i*DW +: DW]  = pd[i];
    end
  endtask

  function automatic int model_grant();
    if (!m_run || stall || clear) return -1;
    for (int k = 0; k < NREQ; k++) begin
      int i = (m_ptr + k) % NREQ;
      if (pv[i]) return i;
    end
    return -1;
  endfunction

  // Starts at posedge+1, ends at the next posedge+1.
  task automatic step();
    int g;
    logic [NREQ-1:0] exp_ready;
    logic [RD*DW-1:0] exp_q;
    drive_bus();
    #2;
    g = model_grant();
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    check("req_ready", 64'(bus.req_ready), 64'(exp_ready));
    for (int p = 0; p < RD; p++) begin
      logic [AW-1:0] a;
      a = bus.rr[p*AW +: AW];
      exp_q[p*DW +: DW] = bus.q_rf[p*DW +: DW];
`ifdef REGFILE_WR_BYPASS_EN
      if (m_wr && a == m_rw && a != '0) exp_q[p*DW +: DW] = m_d;
`endif
    end
    check("q", 64'(bus.q), 64'(exp_q));
    // Next-state of the model
    if (!m_run) begin
      m_wr = 1'b1; m_rw = AW'(m_cnt); m_d = '0; m_known = 1'b1;
      if (m_cnt == DEPTH - 1) begin m_run = 1'b1; m_cnt = 0; end
      else m_cnt++;
    end else if (clear) begin
      m_run = 1'b0; m_cnt = 0; m_wr = 1'b0;
    end else if (g >= 0) begin
      m_wr = (pa[g] != '0);
      m_rw = pa[g]; m_d = pd[g];
      m_known = m_wr;
      m_ptr = (g + 1) % NREQ;
      pv[g] = 1'b0;
    end else begin
      m_wr = 1'b0;
    end
    @(posedge clk);
    #1;
    check("wr", 64'(bus.wr), 64'(m_wr));
    check("init_done", 64'(init_done), 64'(m_run));
    if (m_known) begin
      check("rw", 64'(bus.rw), 64'(m_rw));
      check("d", 64'(bus.d), 64'(m_d));
    end
  endtask

  // Asynchronous reset pulse, released on the falling edge.
  task automatic do_reset();
    rst = 1'b0;
    #1;
    m_run = 1'b0; m_cnt = 0; m_ptr = 0; m_wr = 1'b0; m_rw = '0; m_d = '0; m_known = 1'b1;
    check("rst_wr", 64'(bus.wr), 64'd0);
    check("rst_rw", 64'(bus.rw), 64'd0);
    check("rst_d", 64'(bus.d), 64'd0);
    check("rst_init_done", 64'(init_done), 64'd0);
    check("rst_ready", 64'(bus.req_ready), 64'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < NREQ; i++) begin
      if (!pv[i] && $urandom_range(0, 9) < 6) begin
        pv[i] = 1'b1;
        pa[i] = ($urandom_range(0, 9) == 0) ? '0 : AW'($urandom);
        pd[i] = $urandom;
      end
    end
    stall = ($urandom_range(0, 4) == 0);
    clear = ($urandom_range(0, 99) == 0);
    for (int p = 0; p < RD; p++) begin
      bus.rr[p*AW +: AW] = ($urandom_range(0, 2) == 0) ? m_rw : AW'($urandom);
    end
    bus.q_rf = {$urandom, $urandom};
  endtask

  initial begin
    rst = 1'b0; clear = 1'b0; stall = 1'b0;
    bus.rr = '0; bus.q_rf = '0;
    for (int i = 0; i < NREQ; i++) begin pv[i] = 1'b0; pa[i] = '0; pd[i] = '0; end
    drive_bus();
    do_reset();

    // Requests wait through the fill; stall/clear must be ignored there.
    pv[0] = 1'b1; pa[0] = 5'd27; pd[0] = 32'hdcaf484c;
    pv[1] = 1'b1; pa[1] = 5'd4;  pd[1] = 32'h37373737;
    for (int c = 0; c < DEPTH; c++) begin
      stall = c[0];
      clear = (c % 7 == 3);
      step();
    end
    stall = 1'b0; clear = 1'b0;
    step();  // grant requester 0 -> rw=27
    bus.rr = {5'd4, 5'd27};
    bus.q_rf = '0;
    step();  // q port0 sees bypass when enabled; grant requester 1 -> rw=4
    clear = 1'b1;
    step();  // rw=4 write completes; back to fill
    clear = 1'b0;
    for (int c = 0; c < 11; c++) step();
    do_reset();  // mid-fill at address 10
    for (int c = 0; c < DEPTH; c++) step();

    // Write to $zero: accepted, but no write.
    pv[0] = 1'b1; pa[0] = '0; pd[0] = 32'hffffffff;
    pv[1] = 1'b0;
    bus.rr = '0;
    step();
    step();

    // Stall blocks both; release grants the requester at the pointer.
    pv[0] = 1'b1; pa[0] = 5'd9;  pd[0] = 32'h11112222;
    pv[1] = 1'b1; pa[1] = 5'd17; pd[1] = 32'h33334444;
    stall = 1'b1;
    step();
    step();
    stall = 1'b0;
    step();
    step();

    for (int n = 0; n < 2000; n++) begin
      rand_inputs();
      if ($urandom_range(0, 499) == 0) do_reset();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
